// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO offsets, lane masks, region decode type and lane helpers for data_mem_responder
package dmem_pkg;

    localparam logic [31:0] TOHOST_DEFAULT = 32'h0000_1000;
    localparam logic [31:0] CYCLE_DEFAULT  = 32'h0000_1004;

    localparam logic [3:0] WEN_WORD    = 4'b1111;
    localparam logic [3:0] WEN_HALF_LO = 4'b0011;
    localparam logic [3:0] WEN_HALF_HI = 4'b1100;
    localparam logic [3:0] WEN_B0      = 4'b0001;
    localparam logic [3:0] WEN_B1      = 4'b0010;
    localparam logic [3:0] WEN_B2      = 4'b0100;
    localparam logic [3:0] WEN_B3      = 4'b1000;

    typedef enum logic [1:0] {REG_RAM, REG_TOHOST, REG_CYCLE, REG_NONE} region_t;

    function automatic logic wen_legal(input logic [3:0] wen);
        return wen inside {WEN_WORD, WEN_HALF_LO, WEN_HALF_HI, WEN_B0, WEN_B1, WEN_B2, WEN_B3};
    endfunction

    function automatic logic [31:0] merge_lanes(input logic [31:0] base, input logic [31:0] data,
                                                input logic [3:0] lanes);
        logic [31:0] r;
        r = base;
        for (int i = 0; i < 4; i++)
            if (lanes[i]) r[8*i +: 8] = data[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: one-entry posted-write buffer; drives the RAM commit and forwards pending lanes to reads
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [29:0]   ld_word,
    input  logic [3:0]    ld_lanes,
    input  logic [31:0]   ld_data,
    input  logic [29:0]   rd_word,
    input  logic [31:0]   ram_word,
    output logic [31:0]   rd_data,
    output logic          commit,
    output logic [AW-1:0] cm_idx,
    output logic [3:0]    cm_lanes,
    output logic [31:0]   cm_data
);

    logic        valid;
    logic [29:0] word;
    logic [3:0]  lanes;
    logic [31:0] data;

    // a new write may load on the same edge the old one commits
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= 1'b0;
            word  <= '0;
            lanes <= '0;
            data  <= '0;
        end else begin
            valid <= load;
            if (load) begin
                word  <= ld_word;
                lanes <= ld_lanes;
                data  <= ld_data;
            end
        end

    assign rd_data  = merge_lanes(ram_word, data, (valid && word == rd_word) ? lanes : 4'b0000);
    assign commit   = valid;
    assign cm_idx   = word[AW-1:0];
    assign cm_lanes = lanes;
    assign cm_data  = data;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: CPU data-memory responder with posted-write RAM, tohost/cycle MMIO and sticky bus error.
// Define DMEM_TRACE_EN to print a line per RAM commit, tohost write and bus error (simulation only).
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_DEFAULT,
    parameter logic [31:0] CYCLE_ADDR  = CYCLE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_mem_addr,
    input  logic [31:0] d_mem_wdata,
    input  logic [3:0]  d_mem_wen,
    output logic [31:0] d_mem_rdata,
    output logic        test_done,
    output logic [31:0] test_code,
    output logic        bus_err,
    output logic [31:0] err_addr
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [31:0]   mem [MEM_WORDS];
    logic [31:0]   cycle;
    region_t       region;
    logic          wr, ram_wr, tohost_wr, err_wr;
    logic          commit;
    logic [AW-1:0] cm_idx;
    logic [3:0]    cm_lanes;
    logic [31:0]   cm_data, ram_rd, fwd_rd;

    always_comb
        region = (d_mem_addr == TOHOST_ADDR)           ? REG_TOHOST :
                 (d_mem_addr == CYCLE_ADDR)            ? REG_CYCLE  :
                 (d_mem_addr[31:2] < 30'(MEM_WORDS))   ? REG_RAM    : REG_NONE;

    assign wr        = |d_mem_wen;
    assign ram_wr    = wr && wen_legal(d_mem_wen) && region == REG_RAM;
    assign tohost_wr = wr && region == REG_TOHOST && d_mem_wen == WEN_WORD;
    // repeat tohost word writes are silently ignored, never an error
    assign err_wr    = wr && !ram_wr && !tohost_wr;

    assign ram_rd = mem[d_mem_addr[AW+1:2]];

    dmem_wbuf #(.AW(AW)) u_wbuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ram_wr),
        .ld_word  (d_mem_addr[31:2]),
        .ld_lanes (d_mem_wen),
        .ld_data  (d_mem_wdata),
        .rd_word  (d_mem_addr[31:2]),
        .ram_word (ram_rd),
        .rd_data  (fwd_rd),
        .commit   (commit),
        .cm_idx   (cm_idx),
        .cm_lanes (cm_lanes),
        .cm_data  (cm_data)
    );

    assign d_mem_rdata = (region == REG_RAM)   ? fwd_rd :
                         (region == REG_CYCLE) ? cycle  : 32'h0000_0000;

    always_ff @(posedge clk)
        if (commit)
            for (int i = 0; i < 4; i++)
                if (cm_lanes[i]) mem[cm_idx][8*i +: 8] <= cm_data[8*i +: 8];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cycle     <= '0;
            test_done <= 1'b0;
            test_code <= '0;
            bus_err   <= 1'b0;
            err_addr  <= '0;
        end else begin
            cycle <= cycle + 32'd1;
            if (tohost_wr && !test_done) begin
                test_done <= 1'b1;
                test_code <= d_mem_wdata;
            end
            if (err_wr && !bus_err) begin
                bus_err  <= 1'b1;
                err_addr <= d_mem_addr;
            end
        end

`ifdef DMEM_TRACE_EN
    always @(posedge clk) begin
        if (commit)
            $display("%0t dmem commit addr=%h lanes=%b data=%h", $time, 32'(cm_idx) << 2, cm_lanes,
                     merge_lanes(mem[cm_idx], cm_data, cm_lanes));
        if (rst_n && tohost_wr)
            $display("%0t dmem tohost data=%h", $time, d_mem_wdata);
        if (rst_n && err_wr)
            $display("%0t dmem bus error addr=%h wen=%b", $time, d_mem_addr, d_mem_wen);
    end
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and random stimulus against an architectural model of the data-memory responder
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] d_mem_addr = '0, d_mem_wdata = '0;
    logic [3:0]  d_mem_wen = '0;
    logic [31:0] d_mem_rdata, test_code, err_addr;
    logic        test_done, bus_err;

    int checks = 0, failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .d_mem_addr  (d_mem_addr),
        .d_mem_wdata (d_mem_wdata),
        .d_mem_wen   (d_mem_wen),
        .d_mem_rdata (d_mem_rdata),
        .test_done   (test_done),
        .test_code   (test_code),
        .bus_err     (bus_err),
        .err_addr    (err_addr)
    );

    // model: every accepted store is architecturally visible from the next edge on;
    // a reset undoes the store accepted at the last edge because it never reached memory
    logic [31:0] arch [1024];
    logic        u_valid = 1'b0;
    logic [9:0]  u_word = '0;
    logic [31:0] u_old = '0;
    logic        m_done = 1'b0, m_err = 1'b0;
    logic [31:0] m_code = '0, m_eaddr = '0, m_cyc = '0;

    function automatic bit is_legal(input logic [3:0] w);
        return w == 4'hF || w == 4'h3 || w == 4'hC || $onehot(w);
    endfunction

    function automatic logic [31:0] apply(input logic [31:0] old, input logic [31:0] d, input logic [3:0] w);
        logic [31:0] mask;
        mask = {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
        return (old & ~mask) | (d & mask);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] a);
        if (a < 32'h1000) return arch[a[11:2]];
        if (a == 32'h1004) return m_cyc;
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (u_valid) arch[u_word] <= u_old;
            u_valid <= 1'b0;
            m_done  <= 1'b0;
            m_code  <= '0;
            m_err   <= 1'b0;
            m_eaddr <= '0;
            m_cyc   <= '0;
        end else begin
            m_cyc   <= m_cyc + 32'd1;
            u_valid <= 1'b0;
            if (d_mem_wen != 4'h0) begin
                if (d_mem_addr < 32'h1000 && is_legal(d_mem_wen)) begin
                    u_valid <= 1'b1;
                    u_word  <= d_mem_addr[11:2];
                    u_old   <= arch[d_mem_addr[11:2]];
                    arch[d_mem_addr[11:2]] <= apply(arch[d_mem_addr[11:2]], d_mem_wdata, d_mem_wen);
                end else if (d_mem_addr == 32'h1000 && d_mem_wen == 4'hF) begin
                    if (!m_done) begin
                        m_done <= 1'b1;
                        m_code <= d_mem_wdata;
                    end
                end else if (!m_err) begin
                    m_err   <= 1'b1;
                    m_eaddr <= d_mem_addr;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk)
        if (chk_en && rst_n) begin
            chk("rdata", d_mem_rdata, exp_rdata(d_mem_addr));
            chk("test_done", 32'(test_done), 32'(m_done));
            chk("test_code", test_code, m_code);
            chk("bus_err", 32'(bus_err), 32'(m_err));
            chk("err_addr", err_addr, m_eaddr);
        end

    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
        @(posedge clk);
        #1;
        d_mem_addr  = a;
        d_mem_wdata = d;
        d_mem_wen   = w;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
        if (r == 6) return 32'($urandom_range(0, 4095));
        if (r == 7) return 32'h1000;
        if (r == 8) return 32'h1004;
        return $urandom_range(0, 1) == 0 ? 32'h1008 + 32'($urandom_range(0, 255)) : $urandom;
    endfunction

    function automatic logic [3:0] rand_wen();
        logic [3:0] lw [7];
        int r;
        lw = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8};
        r = $urandom_range(0, 9);
        if (r < 4) return 4'h0;
        if (r < 8) return lw[$urandom_range(0, 6)];
        return 4'($urandom_range(1, 15));
    endfunction

    logic [31:0] c1, c2;

    initial begin
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        // bring every RAM word to a known zero so the model starts from a defined image
        for (int i = 0; i < 1024; i++) step(32'(i * 4), 32'h0, 4'hF);
        step(32'h0, 32'h0, 4'h0);
        step(32'h0, 32'h0, 4'h0);
        chk_en = 1'b1;

        // forwarded then committed word
        step(32'h10, 32'h1234_5678, 4'hF);
        step(32'h10, 32'h0, 4'h0);
        @(negedge clk); chk("t1_fwd", d_mem_rdata, 32'h1234_5678);
        step(32'h10, 32'h0, 4'h0);
        step(32'h10, 32'h0, 4'h0);
        @(negedge clk); chk("t1_ram", d_mem_rdata, 32'h1234_5678);

        // byte write over a still-pending word
        step(32'h20, 32'hFFFF_FFFF, 4'hF);
        step(32'h20, 32'h0000_00AA, 4'h1);
        step(32'h20, 32'h0, 4'h0);
        @(negedge clk); chk("t2_merge", d_mem_rdata, 32'hFFFF_FFAA);

        // back-to-back halfwords to the same word
        step(32'h30, 32'h0, 4'hF);
        step(32'h30, 32'h0000_1111, 4'h3);
        step(32'h30, 32'h2222_0000, 4'hC);
        @(negedge clk); chk("t3_lo", d_mem_rdata, 32'h0000_1111);
        step(32'h30, 32'h0, 4'h0);
        @(negedge clk); chk("t3_both", d_mem_rdata, 32'h2222_1111);
        repeat (3) step(32'h30, 32'h0, 4'h0);
        @(negedge clk); chk("t3_drain", d_mem_rdata, 32'h2222_1111);

        // tohost capture, later write ignored, cycle counter advancing
        step(32'h1000, 32'h1, 4'hF);
        step(32'h0, 32'h0, 4'h0);
        @(negedge clk); chk("t4_done", 32'(test_done), 32'h1); chk("t4_code", test_code, 32'h1);
        step(32'h1000, 32'h5, 4'hF);
        step(32'h1004, 32'h0, 4'h0);
        @(negedge clk); chk("t4_code_kept", test_code, 32'h1); chk("t4_no_err", 32'(bus_err), 32'h0);
        c1 = d_mem_rdata;
        step(32'h1004, 32'h0, 4'h0);
        @(negedge clk); c2 = d_mem_rdata;
        chk("t4_cycle_delta", c2 - c1, 32'h1);

        // illegal lane mask, then an unmapped write
        step(32'h40, 32'hDEAD_BEEF, 4'b0101);
        step(32'h40, 32'h0, 4'h0);
        @(negedge clk); chk("t5_err", 32'(bus_err), 32'h1); chk("t5_eaddr", err_addr, 32'h40);
        chk("t5_ram_kept", d_mem_rdata, 32'h0);
        step(32'h2000, 32'hFFFF_FFFF, 4'hF);
        step(32'h2000, 32'h0, 4'h0);
        @(negedge clk); chk("t5_eaddr_kept", err_addr, 32'h40); chk("t5_unmapped", d_mem_rdata, 32'h0);

        // reset between capture and commit drops the pending write
        step(32'h50, 32'hCAFE_F00D, 4'hF);
        step(32'h50, 32'h0, 4'h0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_rdata", d_mem_rdata, 32'h0);
        chk("t6_rst_done", 32'(test_done), 32'h0);
        chk("t6_rst_code", test_code, 32'h0);
        chk("t6_rst_err", 32'(bus_err), 32'h0);
        chk("t6_rst_eaddr", err_addr, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk); chk("t6_dropped", d_mem_rdata, 32'h0);
        repeat (2) step(32'h50, 32'h0, 4'h0);
        @(negedge clk); chk("t6_still_zero", d_mem_rdata, 32'h0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                @(negedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            step(rand_addr(), $urandom, rand_wen());
        end
        step(32'h0, 32'h0, 4'h0);
        @(negedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
